clock_gen: RTL and testbench

- Programmable system clock generator for the CPU board: derives the CPU clock from a free-running reference clock.
- The divide ratio is set by a 3-bit select; the output can be stopped cleanly (held low) for halting the CPU.
- clk_out drives cpu_top and the bus peripherals. clk_en is a one-reference-cycle strobe for logic that runs on the reference clock.
- Ratio changes and stop/start are glitch-free: they take effect only at a full-period boundary.

---
 rtl/clock_gen_pkg.sv | 17 +
 rtl/clock_gen_sync_ff.sv | 25 ++
 rtl/clock_gen.sv | 123 ++++++++++++
 tb/tb_clock_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/clock_gen_pkg.sv
// Shared definitions for the CPU clock generator: select limits, half-period
// lookup and the control-state encoding.
package pa_clock;

  localparam logic [2:0] CLK_SEL_MAX = 3'b111;

  typedef enum logic [1:0] {
    CG_RUN    = 2'd0,
    CG_PARKED = 2'd1,
    CG_STEP   = 2'd2
  } cg_state_t;

  function automatic logic [7:0] half_period(input logic [2:0] sel);
    return 8'd1 << sel;
  endfunction

endpackage

// File: rtl/clock_gen_sync_ff.sv
// N-stage flop chain for bringing asynchronous control inputs into the clk
// domain; all stages clear on arst.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] chain;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/clock_gen.sv
// Programmable CPU clock generator: divides clk by 2^(clk_sel+1) with
// glitch-free ratio change and stop/start. Define CLOCK_STEP_EN to add step_req.
//
// state     | meaning
// CG_RUN    | clk_out toggling, ratio/stop sampled at each falling boundary
// CG_PARKED | clk_out held low, cnt held 0, waiting for stop_clk=0 (or a step)
// CG_STEP   | one single-shot period (H low, H high) while otherwise parked
module clock_gen
  import pa_clock::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [2:0] clk_sel,
  input  logic       stop_clk,
`ifdef CLOCK_STEP_EN
  input  logic       step_req,
`endif
  output logic       clk_out,
  output logic       clk_en,
  output logic       running
);

  logic [2:0]       sel_s;
  logic             stop_s;
  logic [2:0]       active_sel;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             step_rise;
  cg_state_t        state;

  sync_ff #(.STAGES(SYNC_STAGES), .W(3)) u_sync_sel (
    .clk  (clk),
    .arst (arst),
    .d    (clk_sel),
    .q    (sel_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .W(1)) u_sync_stop (
    .clk  (clk),
    .arst (arst),
    .d    (stop_clk),
    .q    (stop_s)
  );

`ifdef CLOCK_STEP_EN
  logic step_s;
  logic step_d;

  sync_ff #(.STAGES(SYNC_STAGES), .W(1)) u_sync_step (
    .clk  (clk),
    .arst (arst),
    .d    (step_req),
    .q    (step_s)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      step_d <= 1'b0;
    end else begin
      step_d <= step_s;
    end
  end

  assign step_rise = step_s & ~step_d;
`else
  assign step_rise = 1'b0;
`endif

  assign cnt_last = (cnt == CNT_W'(half_period(active_sel) - 8'd1));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= CG_RUN;
      cnt        <= '0;
      clk_out    <= 1'b0;
      clk_en     <= 1'b0;
      active_sel <= 3'b000;
      running    <= 1'b1;
    end else begin
      clk_en <= 1'b0;
      case (state)
        CG_RUN, CG_STEP: begin
          if (cnt_last) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            clk_en  <= ~clk_out;
            // falling edge is the only point where ratio and stop may change
            if (clk_out) begin
              active_sel <= sel_s;
              if (state == CG_STEP) begin
                state <= CG_PARKED;
              end else if (stop_s) begin
                state   <= CG_PARKED;
                running <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CG_PARKED: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          if (!stop_s) begin
            active_sel <= sel_s;
            running    <= 1'b1;
            state      <= CG_RUN;
          end else if (step_rise) begin
            active_sel <= sel_s;
            state      <= CG_STEP;
          end
        end
        default: begin
          state <= CG_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_gen.sv
// Directed self-checking bench for clock_gen; the single-step sequence runs
// only when CLOCK_STEP_EN is defined.
module tb_clock_gen;
  import pa_clock::*;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [2:0] clk_sel = 3'b000;
  logic       stop_clk = 1'b0;
`ifdef CLOCK_STEP_EN
  logic       step_req = 1'b0;
`endif
  logic       clk_out;
  logic       clk_en;
  logic       running;

  int checks = 0;
  int errors = 0;

  clock_gen #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk      (clk),
    .arst     (arst),
    .clk_sel  (clk_sel),
    .stop_clk (stop_clk),
`ifdef CLOCK_STEP_EN
    .step_req (step_req),
`endif
    .clk_out  (clk_out),
    .clk_en   (clk_en),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int n, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0b expected=%0b", tag, n, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int n, input logic eo, input logic ee, input logic er);
    chk({tag, "_clk_out"}, n, clk_out, eo);
    chk({tag, "_clk_en"}, n, clk_en, ee);
    chk({tag, "_running"}, n, running, er);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] sel, input logic stp, input int hold);
    arst     = 1'b1;
    clk_sel  = sel;
    stop_clk = stp;
    repeat (hold) @(posedge clk);
    #1;
    chk3("reset", 0, 1'b0, 1'b0, 1'b1);
    arst = 1'b0;
  endtask

  initial begin
    logic eo, ee, er;
    int p;

    // divide by 2 straight out of a long reset
    do_reset(3'b000, 1'b0, 50);
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk3("t1", n, (n % 2) == 1, (n % 2) == 1, 1'b1);
    end

    // /16 after the select reaches a boundary, then switch to /2 mid high phase
    do_reset(3'b011, 1'b0, 4);
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n <= 4) begin
        eo = (n % 2) == 1;
        ee = eo;
      end else if (n < 52) begin
        p  = (n - 4) / 8;
        eo = (p % 2) == 1;
        ee = eo && ((n - 4) % 8 == 0);
      end else begin
        eo = ((n - 52) % 2) == 1;
        ee = eo;
      end
      if (n < 46) chk3("t2", n, eo, ee, 1'b1);
      else        chk3("t3", n, eo, ee, 1'b1);
      if (n == 46) clk_sel = 3'b000;
    end

    // stop mid high phase at /8, park, then restart
    do_reset(3'b010, 1'b0, 4);
    for (int n = 1; n <= 44; n++) begin
      tick();
      if (n <= 4) begin
        eo = (n % 2) == 1;
        ee = eo;
        er = 1'b1;
      end else if (n < 20) begin
        p  = (n - 4) / 4;
        eo = (p % 2) == 1;
        ee = eo && ((n - 4) % 4 == 0);
        er = 1'b1;
      end else if (n < 33) begin
        eo = 1'b0;
        ee = 1'b0;
        er = 1'b0;
      end else begin
        p  = (n - 33) / 4;
        eo = (p % 2) == 1;
        ee = eo && ((n - 33) % 4 == 0);
        er = 1'b1;
      end
      chk3("t4", n, eo, ee, er);
      if (n == 17) stop_clk = 1'b1;
      if (n == 30) stop_clk = 1'b0;
    end

    // /256: first 128-cycle low phase, then reset while clk_out is high
    do_reset(CLK_SEL_MAX, 1'b0, 4);
    for (int n = 1; n <= 132; n++) begin
      tick();
      if (n <= 4) eo = (n % 2) == 1;
      else        eo = (n == 132);
      chk3("t5", n, eo, eo, 1'b1);
    end
    arst = 1'b1;
    #1;
    chk3("t5_arst", 0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      eo = (n <= 4) && ((n % 2) == 1);
      chk3("t5_post", n, eo, eo, 1'b1);
    end

`ifdef CLOCK_STEP_EN
    // park at /4, then two step pulses close together give one period
    do_reset(3'b001, 1'b1, 4);
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (n <= 4) begin
        eo = (n % 2) == 1;
        ee = eo;
        er = (n < 4);
      end else begin
        eo = (n == 13) || (n == 14);
        ee = (n == 13);
        er = 1'b0;
      end
      chk3("t6", n, eo, ee, er);
      if (n == 8)  step_req = 1'b1;
      if (n == 9)  step_req = 1'b0;
      if (n == 10) step_req = 1'b1;
      if (n == 11) step_req = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
